// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared types and byte-mask helper for the program memory
package prog_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        LD_IDLE = 2'b00,
        LD_LOAD = 2'b01,
        LD_DONE = 2'b10
    } ld_state_e;

    // Byte lanes touched by a store of the given size; the unused 2'b11
    // encoding falls through to a full word.
    function automatic logic [3:0] size_mask(input size_e sz);
        case (sz)
            SZ_B:    size_mask = 4'b0001;
            SZ_H:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/prog_mem_if.sv
// rtl/prog_mem_if.sv - fetch, data and loader port bundle for prog_mem_2p
// master: core/loader side driving requests; slave: the memory.
interface prog_mem_if #(
    parameter int ADDR_W = 15
);
    // instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    // load/store port
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_valid;
    // byte-stream loader port
    logic              ld_start;
    logic              ld_valid;
    logic [7:0]        ld_byte;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
               ld_start, ld_valid, ld_byte, ld_last,
        input  if_rdata, if_valid, d_rdata, d_valid, ld_ready, ld_done, busy
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata,
               ld_start, ld_valid, ld_byte, ld_last,
        output if_rdata, if_valid, d_rdata, d_valid, ld_ready, ld_done, busy
    );

endinterface

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - byte-stream loader FSM and write pointer
// Ports: clk, rst_n; ld_start/ld_valid/ld_last in; ld_ready/ld_done/busy out;
//        wr_en/wr_addr tell the top which byte to write with the current ld_byte.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int MEM_BYTES = 32768,
    localparam int ADDR_W   = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    ld_state_e         state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LD_IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // busy covers LOAD only, so the core ports reopen in the ld_done cycle.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        ld_ready  = 1'b0;
        ld_done   = 1'b0;
        busy      = 1'b0;
        wr_en     = 1'b0;
        case (state)
            LD_IDLE: begin
                if (ld_start) begin
                    state_nxt = LD_LOAD;
                    ptr_nxt   = '0;
                end
            end
            LD_LOAD: begin
                busy     = 1'b1;
                ld_ready = 1'b1;
                if (ld_valid) begin
                    wr_en   = 1'b1;
                    ptr_nxt = ptr + 1'b1;
                    // the final memory byte ends the image even without ld_last
                    if (ld_last || ptr == LAST_ADDR) state_nxt = LD_DONE;
                end
            end
            LD_DONE: begin
                ld_done   = 1'b1;
                state_nxt = LD_IDLE;
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    assign wr_addr = ptr;

endmodule

// File: rtl/prog_mem_2p.sv
// rtl/prog_mem_2p.sv - byte-addressed little-endian memory with fetch, data and loader ports
// Ports: clk, rst_n (async active-low); bus (prog_mem_if.slave) carrying the
//        fetch port (if_*), load/store port (d_*) and byte loader (ld_*, busy).
module prog_mem_2p
    import prog_mem_pkg::*;
#(
    parameter int         MEM_BYTES = 32768,
    parameter logic [7:0] INIT_BYTE = 8'hFF,
    localparam int        ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic      clk,
    input  logic      rst_n,
    prog_mem_if.slave bus
);

    // Power-up contents only; reset never touches the array.
    logic [7:0] mem [MEM_BYTES] = '{default: INIT_BYTE};

    logic              busy;
    logic              ld_wr_en;
    logic [ADDR_W-1:0] ld_wr_addr;
    logic              if_fire, d_fire, st_fire;
    logic [3:0]        st_mask;

    prog_mem_loader #(.MEM_BYTES(MEM_BYTES)) u_loader (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (bus.ld_start),
        .ld_valid (bus.ld_valid),
        .ld_last  (bus.ld_last),
        .ld_ready (bus.ld_ready),
        .ld_done  (bus.ld_done),
        .busy     (busy),
        .wr_en    (ld_wr_en),
        .wr_addr  (ld_wr_addr)
    );

    assign bus.busy = busy;

    // Core requests are simply dropped while the loader owns the array, so
    // loader and store writes can never collide.
    assign if_fire = bus.if_req & ~busy;
    assign d_fire  = bus.d_req & ~busy;
    assign st_fire = d_fire & bus.d_we;
    assign st_mask = size_mask(size_e'(bus.d_size));

    // Four bytes starting at a, wrapping at the top of memory.
    function automatic logic [31:0] read_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] a1, a2, a3;
        a1 = a + ADDR_W'(1);
        a2 = a + ADDR_W'(2);
        a3 = a + ADDR_W'(3);
        read_word = {mem[a3], mem[a2], mem[a1], mem[a]};
    endfunction

    always_ff @(posedge clk) begin
        if (st_fire) begin
            for (int k = 0; k < 4; k++) begin
                if (st_mask[k]) mem[bus.d_addr + ADDR_W'(k)] <= bus.d_wdata[8*k +: 8];
            end
        end
        if (ld_wr_en) mem[ld_wr_addr] <= bus.ld_byte;
    end

    // Reads sample the array before this edge's writes land: read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rdata <= '0;
            bus.if_valid <= 1'b0;
            bus.d_rdata  <= '0;
            bus.d_valid  <= 1'b0;
        end else begin
            bus.if_valid <= if_fire;
            bus.d_valid  <= d_fire;
            if (if_fire) bus.if_rdata <= read_word(bus.if_addr);
            if (d_fire && !bus.d_we) bus.d_rdata <= read_word(bus.d_addr);
        end
    end

endmodule

// File: tb/tb_prog_mem_2p.sv
// tb/tb_prog_mem_2p.sv - directed self-checking bench for prog_mem_2p
module tb_prog_mem_2p;
    import prog_mem_pkg::*;

    localparam int MEM_BYTES = 32768;
    localparam int ADDR_W    = $clog2(MEM_BYTES);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    prog_mem_if #(.ADDR_W(ADDR_W)) bus ();

    prog_mem_2p #(.MEM_BYTES(MEM_BYTES), .INIT_BYTE(8'hFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge; outputs are then sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        step();
        bus.if_req  = 1'b0;
        chk({tag, "_valid"}, bus.if_valid, 1);
        chk(tag, bus.if_rdata, exp);
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [1:0] sz, input logic [31:0] d);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_size  = sz;
        bus.d_addr  = a;
        bus.d_wdata = d;
        step();
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        chk("store_ack", bus.d_valid, 1);
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_size = SZ_W;
        bus.d_addr = a;
        step();
        bus.d_req  = 1'b0;
        chk({tag, "_valid"}, bus.d_valid, 1);
        chk(tag, bus.d_rdata, exp);
    endtask

    task automatic ld_push(input logic [7:0] b, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        bus.ld_last  = last;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    initial begin
        logic [7:0] img [8];
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_addr = '0; bus.d_wdata = '0;
        bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_byte = '0; bus.ld_last = 1'b0;

        // 1: reset values, first fetch of untouched memory
        step(); step();
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_d_valid", bus.d_valid, 0);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_ld_done", bus.ld_done, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        step();
        fetch(0, 32'hFFFF_FFFF, "fetch0");
        step();
        chk("if_valid_idle", bus.if_valid, 0);
        chk("if_rdata_hold", bus.if_rdata, 32'hFFFF_FFFF);

        // 2: word store, byte and half stores using only low data bytes
        store(15'h10, SZ_W, 32'h1234_5678);
        load(15'h10, 32'h1234_5678, "lw_10");
        store(15'h11, SZ_B, 32'hFFFF_FFAB);
        load(15'h10, 32'h1234_AB78, "lw_after_sb");
        store(15'h12, SZ_H, 32'h5555_BEEF);
        load(15'h10, 32'hBEEF_AB78, "lw_after_sh");
        store(15'h40, 2'b11, 32'hCAFE_F00D);
        load(15'h40, 32'hCAFE_F00D, "lw_size11");

        // 3: unaligned and wrapping accesses
        store(15'h0, SZ_W, 32'h0302_0100);
        store(15'h4, SZ_W, 32'h0706_0504);
        load(15'h3, 32'h0605_0403, "lw_unaligned");
        load(15'(MEM_BYTES - 2), 32'h0100_FFFF, "lw_wrap");
        store(15'(MEM_BYTES - 1), SZ_H, 32'h0000_2211);
        load(15'(MEM_BYTES - 1), 32'h0201_2211, "lw_sh_wrap");

        // 4: same-cycle store and fetch of the same word returns old data
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = SZ_W;
        bus.d_addr = 15'h20; bus.d_wdata = 32'hDEAD_BEEF;
        fetch(15'h20, 32'hFFFF_FFFF, "fetch_rbw");
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        fetch(15'h20, 32'hDEAD_BEEF, "fetch_after_sw");

        // 5: loader; the load issued with ld_start is still serviced
        bus.ld_start = 1'b1;
        load(15'h10, 32'hBEEF_AB78, "lw_at_start");
        bus.ld_start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        chk("ready_after_start", bus.ld_ready, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = SZ_W;
                bus.d_addr = 15'h10; bus.d_wdata = 32'h0;
            end
            if (i == 4) bus.ld_start = 1'b1;
            ld_push(img[i], i == 7);
            bus.d_req = 1'b0; bus.d_we = 1'b0; bus.ld_start = 1'b0;
            if (i == 2) chk("no_dvalid_busy", bus.d_valid, 0);
            chk("ld_busy", bus.busy, (i < 7) ? 1 : 0);
            chk("ld_done_pulse", bus.ld_done, (i == 7) ? 1 : 0);
        end
        step();
        chk("ld_done_once", bus.ld_done, 0);
        chk("busy_idle", bus.busy, 0);
        fetch(15'h0, 32'h0000_0013, "fetch_img0");
        fetch(15'h4, 32'h0010_0093, "fetch_img4");
        load(15'h10, 32'hBEEF_AB78, "no_store_busy");

        // 6: reset in the middle of a load
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        ld_push(8'hAA, 1'b0);
        ld_push(8'hBB, 1'b0);
        ld_push(8'hCC, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.ld_ready, 0);
        chk("midrst_done", bus.ld_done, 0);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("midrst_no_done", bus.ld_done, 0);
        fetch(15'h0, 32'h00CC_BBAA, "fetch_retained");
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        ld_push(8'h5A, 1'b1);
        chk("restart_done", bus.ld_done, 1);
        step();
        fetch(15'h0, 32'h00CC_BB5A, "fetch_restart");

        // full-depth load ends on the last byte without ld_last
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (i == MEM_BYTES - 1) chk("full_busy_before_last", bus.busy, 1);
            ld_push(8'(i), 1'b0);
        end
        chk("full_done", bus.ld_done, 1);
        chk("full_busy_drop", bus.busy, 0);
        step();
        fetch(15'(MEM_BYTES - 2), 32'h0100_FFFE, "fetch_full_wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
